ram_port_arbiter: RTL



---
 rtl/k_and_s_pkg.sv | 5 +
 rtl/ram_port_arbiter.sv | 92 +++++++++
 2 files changed

// File: rtl/k_and_s_pkg.sv
// k_and_s_pkg: shared types for the RAM port arbiter.
package k_and_s_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
    typedef enum logic {OWNER_CORE, OWNER_DBG} arb_owner_t;
endpackage

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one synchronous-read RAM port between core and debug loader.
module ram_port_arbiter
    import k_and_s_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);
    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d, last_q, last_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
    logic              lat_we_q, lat_we_d;
    logic              pick_core, pick_dbg;

    // On a tie the requester that did not win last time goes first
    always_comb begin
        pick_core = core_req && (!dbg_req || last_q == OWNER_DBG);
        pick_dbg  = dbg_req && !pick_core;
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_we_d    = lat_we_q;
        core_gnt    = 1'b0;
        dbg_gnt     = 1'b0;
        case (state_q)
            ARB_IDLE: if (!rst && (pick_core || pick_dbg)) begin
                core_gnt    = pick_core;
                dbg_gnt     = pick_dbg;
                owner_d     = pick_core ? OWNER_CORE : OWNER_DBG;
                last_d      = pick_core ? OWNER_CORE : OWNER_DBG;
                lat_addr_d  = pick_core ? core_addr : dbg_addr;
                lat_wdata_d = pick_core ? core_wdata : dbg_wdata;
                lat_we_d    = pick_core ? core_we : dbg_we;
                state_d     = ARB_ACCESS;
            end
            ARB_ACCESS: state_d = lat_we_q ? ARB_IDLE : ARB_RESP;
            default:    state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWNER_CORE;
            last_q      <= OWNER_DBG;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_we_q    <= lat_we_d;
        end
    end

    assign ram_addr    = lat_addr_q;
    assign ram_wdata   = lat_wdata_q;
    assign ram_we      = state_q == ARB_ACCESS && lat_we_q;
    assign core_rvalid = state_q == ARB_RESP && owner_q == OWNER_CORE;
    assign dbg_rvalid  = state_q == ARB_RESP && owner_q == OWNER_DBG;
    assign core_rdata  = core_rvalid ? ram_rdata : '0;
    assign dbg_rdata   = dbg_rvalid ? ram_rdata : '0;
endmodule
